sw_debounce_ctrl: RTL

//  Input-side conditioner for the slide switches feeding the LED pattern and rate-divider logic.
//  - Synchronises raw switches into clk_in (5 MHz clock domain) and debounces each channel independently.
//  - Emits clean levels, one-cycle rise/fall strobes, and a rate-select change strobe.
//  - The downstream divider restarts its count on that strobe instead of tracking previous switch values itself.

---
 rtl/sw_debounce_ctrl_pkg.sv | 12 +
 rtl/sw_debounce_ch.sv | 57 +++++
 rtl/sw_debounce_ctrl.sv | 56 +++++
 3 files changed

// File: rtl/sw_debounce_ctrl_pkg.sv
// Shared constants for the slide-switch conditioner: board debounce window,
// matching counter width and the position of the rate-select field.
package sw_debounce_ctrl_pkg;

  localparam int unsigned DEBOUNCE_5MHZ_20MS = 100000;
  localparam int unsigned DEBOUNCE_CNT_W     = 17;
  localparam int unsigned RATE_LSB_DEFAULT   = 2;
  localparam int unsigned N_SW_DEFAULT       = 4;

  typedef logic [1:0] rate_sel_t;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchroniser, stability counter, clean level
// and single-cycle rise/fall strobes coincident with the level change.
module sw_debounce_ch
  import sw_debounce_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_5MHZ_20MS,
  parameter int unsigned CNT_W           = DEBOUNCE_CNT_W
) (
  input  logic clk_in,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clean;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1   <= sw_raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s2 == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_CNT_LAST) begin
        // Accept: counter is cleared here, so it can never wrap.
        r_clean <= r_s2;
        r_cnt   <= '0;
        r_rise  <= r_s2;
        r_fall  <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sw_clean = r_clean;
  assign sw_rise  = r_rise;
  assign sw_fall  = r_fall;

endmodule

// File: rtl/sw_debounce_ctrl.sv
// Switch conditioner top: N_SW independent debounce channels plus the
// registered rate-select copy and its change strobe for the rate divider.
module sw_debounce_ctrl
  import sw_debounce_ctrl_pkg::*;
#(
  parameter int unsigned N_SW            = N_SW_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_5MHZ_20MS,
  parameter int unsigned CNT_W           = DEBOUNCE_CNT_W,
  parameter int unsigned RATE_LSB        = RATE_LSB_DEFAULT
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic [1:0]      rate_sel,
  output logic            rate_chg
);

  logic [N_SW-1:0] w_clean;
  rate_sel_t       w_rate_field;
  rate_sel_t       r_rate_sel;
  logic            r_rate_chg;

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    sw_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .sw_raw  (sw_raw[g]),
      .sw_clean(w_clean[g]),
      .sw_rise (sw_rise[g]),
      .sw_fall (sw_fall[g])
    );
  end

  assign w_rate_field = w_clean[RATE_LSB+1:RATE_LSB];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_rate_sel <= '0;
      r_rate_chg <= 1'b0;
    end else begin
      r_rate_sel <= w_rate_field;
      r_rate_chg <= (w_rate_field != r_rate_sel);
    end
  end

  assign sw_clean = w_clean;
  assign rate_sel = r_rate_sel;
  assign rate_chg = r_rate_chg;

endmodule
